// File: rtl/hack_boot_loader.sv
// Boot sequencer: takes a big-endian word-count-prefixed byte stream and writes it into
// instruction memory, holding the CPU in reset until the image is complete.
module hack_boot_loader #(
  parameter int ROM_DEPTH      = 32768,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  output logic        rom_we,
  output logic [15:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [2:0]  state_dbg
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_ready is a
  // pure decode of the state, so it never depends combinationally on rx_valid.

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_WRITE  = 3'd4,
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam int              TW         = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     DEPTH17    = 17'(ROM_DEPTH);

  state_t        state_q, state_d;
  logic [15:0]   count_q;
  logic [15:0]   index_q;
  logic [7:0]    hi_q;
  logic [TW-1:0] timer_q;

  logic        xfer;
  logic [15:0] n_full;
  logic        last_word;
  logic        timed;
  logic        timeout_hit;
  logic        reload_ok;

  assign rx_ready  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                     (state_q == S_DAT_HI) || (state_q == S_DAT_LO);
  assign xfer      = rx_valid && rx_ready;
  assign n_full    = {count_q[15:8], rx_data};
  assign last_word = (index_q == (count_q - 16'd1));
  assign timed     = (state_q == S_CNT_LO) || (state_q == S_DAT_HI) || (state_q == S_DAT_LO);
  // The idle cycle that would bring the count to the limit trips the error; a transfer
  // on that same cycle takes precedence.
  assign timeout_hit = TIMEOUT_EN && timed && !xfer && (timer_q == TIMER_LAST);
  assign reload_ok   = reload && ((state_q == S_RUN) || (state_q == S_ERROR));

  assign rom_we    = (state_q == S_WRITE);
  assign cpu_reset = (state_q != S_RUN);
  assign done      = (state_q == S_RUN);
  assign error     = (state_q == S_ERROR);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CNT_HI: if (xfer) state_d = S_CNT_LO;
      S_CNT_LO: begin
        if (xfer) begin
          if (n_full == 16'd0)               state_d = S_RUN;
          else if ({1'b0, n_full} > DEPTH17) state_d = S_ERROR;
          else                               state_d = S_DAT_HI;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DAT_HI: begin
        if (xfer)             state_d = S_DAT_LO;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_DAT_LO: begin
        if (xfer)             state_d = S_WRITE;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_WRITE:  state_d = last_word ? S_RUN : S_DAT_HI;
      S_RUN:    if (reload) state_d = S_CNT_HI;
      S_ERROR:  if (reload) state_d = S_CNT_HI;
      default:  state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CNT_HI;
      count_q   <= 16'd0;
      index_q   <= 16'd0;
      hi_q      <= 8'd0;
      rom_addr  <= 16'd0;
      rom_wdata <= 16'd0;
      timer_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CNT_HI && xfer) count_q[15:8] <= rx_data;
      if (state_q == S_CNT_LO && xfer) begin
        count_q[7:0] <= rx_data;
        index_q      <= 16'd0;
      end
      if (state_q == S_DAT_HI && xfer) hi_q <= rx_data;
      // Address/data are staged when the low byte lands so they are stable for the
      // single WRITE cycle and simply hold afterwards.
      if (state_q == S_DAT_LO && xfer) begin
        rom_addr  <= index_q;
        rom_wdata <= {hi_q, rx_data};
      end
      if (state_q == S_WRITE && !last_word) index_q <= index_q + 16'd1;
      if (reload_ok) index_q <= 16'd0;

      if (xfer || (state_d != state_q)) timer_q <= '0;
      else if (TIMEOUT_EN && timed)     timer_q <= timer_q + TW'(1);
    end
  end

endmodule
